// File: rtl/ahb2_sram_slv.sv
// AHB2 slave bridging one decoder port onto a single-port, byte-writable synchronous SRAM.
// Zero-wait reads/writes; one stall when a read address phase lands on a write data phase.
module ahb2_sram_slv #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned MEM_ADDR_WIDTH = 10
) (
   input  logic                      hclk,
   input  logic                      hreset_n,
   input  logic                      hsel,
   input  logic [ADDR_WIDTH-1:0]     haddr,
   input  logic [1:0]                htrans,
   input  logic                      hwrite,
   input  logic [2:0]                hsize,
   input  logic [2:0]                hburst,
   input  logic [3:0]                hprot,
   input  logic [DATA_WIDTH-1:0]     hwdata,
   input  logic                      hready_in,
   output logic [DATA_WIDTH-1:0]     hrdata,
   output logic                      hready,
   output logic [1:0]                hresp,
   output logic                      mem_cs,
   output logic                      mem_we,
   output logic [DATA_WIDTH/8-1:0]   mem_be,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   localparam int unsigned BE_W   = DATA_WIDTH / 8;
   localparam int unsigned BYTE_W = $clog2(BE_W);
   localparam int unsigned HI_LSB = BYTE_W + MEM_ADDR_WIDTH;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RDS,
      S_RD,
      S_ERR1,
      S_ERR2
   } state_e;

   state_e                    state_q, state_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BE_W-1:0]           be_q, be_d;
   logic [DATA_WIDTH-1:0]     hrdata_q, hrdata_d;
   logic                      hready_q, hready_d;
   logic [1:0]                hresp_q, hresp_d;

   logic                      acc_c;
   logic                      illegal_c;
   logic [ADDR_WIDTH-1:0]     align_mask_c;
   logic [31:0]               off_c;
   logic [31:0]               nbytes_c;
   logic [BE_W-1:0]           be_c;
   logic                      unused_ok;

   assign unused_ok = ^{hburst, hprot};

   // Address-phase decode: legality and byte-lane mask of the offered transfer
   always_comb begin
      align_mask_c = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
      illegal_c    = (32'(hsize) > BYTE_W)
                   | (|(haddr & align_mask_c))
                   | (|(haddr >> HI_LSB));
      off_c        = 32'(haddr[BYTE_W-1:0]);
      nbytes_c     = 32'd1 << hsize;
      be_c         = '0;
      for (int unsigned i = 0; i < BE_W; i++) begin
         be_c[i] = (i >= off_c) && (i < off_c + nbytes_c);
      end
   end

   // Next-state, SRAM strobes and registered response
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      be_d      = be_q;
      hrdata_d  = hrdata_q;
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = hwdata;
      acc_c     = hsel & htrans[1] & hready_in;

      case (state_q)
         S_WR: begin
            mem_cs   = 1'b1;
            mem_we   = 1'b1;
            mem_be   = be_q;
            mem_addr = addr_q;
         end
         S_RDS: begin
            mem_cs   = 1'b1;
            mem_be   = be_q;
            mem_addr = addr_q;
            state_d  = S_RD;
         end
         S_RD:    hrdata_d = mem_rdata;
         S_ERR1:  state_d  = S_ERR2;
         default: ;
      endcase

      if (state_q inside {S_IDLE, S_WR, S_RD, S_ERR2}) begin
         state_d = S_IDLE;
         if (acc_c) begin
            if (illegal_c) begin
               state_d = S_ERR1;
            end else begin
               addr_d = haddr[BYTE_W +: MEM_ADDR_WIDTH];
               be_d   = be_c;
               if (hwrite) begin
                  state_d = S_WR;
               end else if (state_q == S_WR) begin
                  // SRAM port busy with the write: park the read for one cycle
                  state_d = S_RDS;
               end else begin
                  mem_cs   = 1'b1;
                  mem_be   = be_c;
                  mem_addr = haddr[BYTE_W +: MEM_ADDR_WIDTH];
                  state_d  = S_RD;
               end
            end
         end
      end

      hready_d = !((state_d == S_RDS) || (state_d == S_ERR1));
      hresp_d  = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? RESP_ERROR : RESP_OKAY;
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         be_q     <= '0;
         hrdata_q <= '0;
         hready_q <= 1'b1;
         hresp_q  <= RESP_OKAY;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         hrdata_q <= hrdata_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
      end
   end

   // Read data flows straight from the SRAM in RD and is held afterwards
   assign hrdata = (state_q == S_RD) ? mem_rdata : hrdata_q;
   assign hready = hready_q;
   assign hresp  = hresp_q;

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// Bench for ahb2_sram_slv: pipelined AHB master, behavioural SRAM, read-data scoreboard.
module tb_ahb2_sram_slv;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned MAW = 10;
   localparam int unsigned BEW = DW / 8;

   logic           hclk = 1'b0;
   logic           hreset_n;
   logic           hsel;
   logic [AW-1:0]  haddr;
   logic [1:0]     htrans;
   logic           hwrite;
   logic [2:0]     hsize;
   logic [2:0]     hburst;
   logic [3:0]     hprot;
   logic [DW-1:0]  hwdata;
   logic           hready_in;
   logic [DW-1:0]  hrdata;
   logic           hready;
   logic [1:0]     hresp;
   logic           mem_cs;
   logic           mem_we;
   logic [BEW-1:0] mem_be;
   logic [MAW-1:0] mem_addr;
   logic [DW-1:0]  mem_wdata;
   logic [DW-1:0]  mem_rdata;

   int checks = 0;
   int errors = 0;
   int cs_cnt = 0;
   int we_cnt = 0;

   logic           pend_valid = 1'b0;
   logic           pend_write = 1'b0;
   logic           pend_err   = 1'b0;
   logic [BEW-1:0] pend_be    = '0;
   logic [DW-1:0]  pend_wdata = '0;
   logic [DW-1:0]  sb_q[$];

   logic [DW-1:0]  sram [0:(1<<MAW)-1];

   always #5 hclk = ~hclk;

   assign hready_in = hready;

   ahb2_sram_slv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW)) dut (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
      .hready_in(hready_in), .hrdata(hrdata), .hready(hready), .hresp(hresp),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge hclk) begin
      if (mem_cs === 1'b1) begin
         if (mem_we === 1'b1) begin
            for (int b = 0; b < BEW; b++)
               if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   always @(negedge hclk) begin
      if (mem_cs === 1'b1) cs_cnt++;
      if (mem_we === 1'b1) we_cnt++;
   end

   // One address phase plus completion of the previous data phase
   task automatic ahb_step(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [2:0] size, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic exp_err,
                           input logic [DW-1:0] exp_rdata, input logic [BEW-1:0] exp_be,
                           output int stalls);
      logic          done;
      logic [DW-1:0] exp;
      hsel   = sel;
      htrans = trans;
      hwrite = wr;
      hsize  = size;
      haddr  = addr;
      hwdata = pend_wdata;
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 8 && !done; c++) begin
         @(negedge hclk);
         if (hready === 1'b1) begin
            done = 1'b1;
         end else begin
            stalls++;
            if (pend_valid && pend_err) begin
               checks++;
               if (hresp !== 2'b01 || mem_cs !== 1'b0) begin
                  errors++;
                  $display("FAIL err_first_cycle: got hresp=%b mem_cs=%b, expected hresp=01 mem_cs=0",
                           hresp, mem_cs);
               end
            end
            @(posedge hclk);
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL hready_timeout: got hready=%b after 8 cycles, expected 1", hready);
      end
      if (done && pend_valid) begin
         checks++;
         if (hresp !== (pend_err ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL data_phase_resp: got %b, expected %b", hresp, pend_err ? 2'b01 : 2'b00);
         end
         if (!pend_err && pend_write) begin
            checks++;
            if (mem_we !== 1'b1 || mem_be !== pend_be) begin
               errors++;
               $display("FAIL write_strobe: got mem_we=%b mem_be=%b, expected mem_we=1 mem_be=%b",
                        mem_we, mem_be, pend_be);
            end
         end
         if (!pend_err && !pend_write) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_empty: got hrdata=%h, expected a queued read", hrdata);
            end else begin
               exp = sb_q.pop_front();
               if (hrdata !== exp) begin
                  errors++;
                  $display("FAIL read_data: got %h, expected %h", hrdata, exp);
               end
            end
         end
      end
      @(posedge hclk);
      #1;
      pend_valid = sel && trans[1];
      pend_write = wr;
      pend_err   = exp_err;
      pend_be    = exp_be;
      pend_wdata = wdata;
      if (pend_valid && !wr && !exp_err) sb_q.push_back(exp_rdata);
   endtask

   task automatic idle_step(output int stalls);
      ahb_step(1'b0, 2'b00, 1'b0, 3'd0, '0, '0, 1'b0, '0, '0, stalls);
   endtask

   task automatic test_reset();
      hreset_n = 1'b0;
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = '0;
      hburst = 3'd0; hprot = 4'd0; hwdata = '0;
      repeat (2) @(posedge hclk);
      #1;
      checks++;
      if (hready !== 1'b1 || hresp !== 2'b00 || hrdata !== '0) begin
         errors++;
         $display("FAIL reset_bus: got hready=%b hresp=%b hrdata=%h, expected 1 00 0",
                  hready, hresp, hrdata);
      end
      checks++;
      if (mem_cs !== 1'b0 || mem_we !== 1'b0 || mem_be !== '0) begin
         errors++;
         $display("FAIL reset_mem: got cs=%b we=%b be=%b, expected 0 0 0000", mem_cs, mem_we, mem_be);
      end
      @(negedge hclk);
      hreset_n = 1'b1;
      @(posedge hclk);
      #1;
   endtask

   task automatic test_write_read();
      int s;
      ahb_step(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, '0, 4'hF, s);
      ahb_step(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, '0, 1'b0, 32'hDEADBEEF, 4'hF, s);
      idle_step(s);
      checks++;
      if (s != 1) begin
         errors++;
         $display("FAIL read_after_write_stall: got %0d stall cycles, expected 1", s);
      end
   endtask

   task automatic test_byte_writes();
      int s;
      for (int i = 0; i < 4; i++)
         ahb_step(1'b1, 2'b10, 1'b1, 3'd0, 32'h20 + 32'(i), (32'(8'h11) * 32'(i + 1)) << (8 * i),
                  1'b0, '0, 4'(1 << i), s);
      idle_step(s);
      ahb_step(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, '0, 1'b0, 32'h44332211, 4'hF, s);
      idle_step(s);
      checks++;
      if (s != 0) begin
         errors++;
         $display("FAIL read_after_idle_stall: got %0d stall cycles, expected 0", s);
      end
   endtask

   task automatic test_back_to_back();
      int s;
      int tot;
      int cs0;
      for (int i = 0; i < 4; i++)
         ahb_step(1'b1, 2'b10, 1'b1, 3'd2, 32'h40 + 32'(4 * i), 32'(i), 1'b0, '0, 4'hF, s);
      idle_step(s);
      cs0 = cs_cnt;
      tot = 0;
      for (int i = 0; i < 4; i++) begin
         ahb_step(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b0, 3'd2, 32'h40 + 32'(4 * i), '0,
                  1'b0, 32'(i), 4'hF, s);
         tot += s;
      end
      idle_step(s);
      tot += s;
      checks++;
      if (tot != 0) begin
         errors++;
         $display("FAIL burst_stalls: got %0d stall cycles, expected 0", tot);
      end
      checks++;
      if (cs_cnt - cs0 != 4) begin
         errors++;
         $display("FAIL burst_mem_cs: got %0d cycles, expected 4", cs_cnt - cs0);
      end
   endtask

   task automatic test_misaligned();
      int s;
      int cs0;
      cs0 = cs_cnt;
      ahb_step(1'b1, 2'b10, 1'b0, 3'd1, 32'h01, '0, 1'b1, '0, '0, s);
      idle_step(s);
      checks++;
      if (s != 1) begin
         errors++;
         $display("FAIL misaligned_err_len: got %0d low cycles, expected 1", s);
      end
      checks++;
      if (cs_cnt - cs0 != 0) begin
         errors++;
         $display("FAIL misaligned_mem_cs: got %0d cycles, expected 0", cs_cnt - cs0);
      end
      ahb_step(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, '0, 1'b0, 32'hDEADBEEF, 4'hF, s);
      idle_step(s);
   endtask

   task automatic test_out_of_range();
      int s;
      int we0;
      ahb_step(1'b1, 2'b10, 1'b1, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0, '0, 4'hF, s);
      idle_step(s);
      we0 = we_cnt;
      ahb_step(1'b1, 2'b10, 1'b1, 3'd2, 32'h1000, 32'h12345678, 1'b1, '0, '0, s);
      idle_step(s);
      checks++;
      if (s != 1 || we_cnt - we0 != 0) begin
         errors++;
         $display("FAIL oob_write: got %0d low cycles and %0d mem_we cycles, expected 1 and 0",
                  s, we_cnt - we0);
      end
      ahb_step(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, '0, 1'b0, 32'hCAFEF00D, 4'hF, s);
      idle_step(s);
   endtask

   task automatic test_reset_in_stall();
      int s;
      ahb_step(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'h5555AAAA, 1'b0, '0, 4'hF, s);
      ahb_step(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, '0, 1'b0, 32'h5555AAAA, 4'hF, s);
      hsel = 1'b0;
      htrans = 2'b00;
      checks++;
      if (hready !== 1'b0) begin
         errors++;
         $display("FAIL stall_before_reset: got hready=%b, expected 0", hready);
      end
      #2;
      hreset_n = 1'b0;
      #1;
      checks++;
      if (hready !== 1'b1 || hresp !== 2'b00 || mem_cs !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_stall: got hready=%b hresp=%b mem_cs=%b, expected 1 00 0",
                  hready, hresp, mem_cs);
      end
      sb_q.delete();
      pend_valid = 1'b0;
      @(negedge hclk);
      hreset_n = 1'b1;
      @(posedge hclk);
      #1;
      ahb_step(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, '0, 1'b0, 32'h5555AAAA, 4'hF, s);
      idle_step(s);
      checks++;
      if (s != 0) begin
         errors++;
         $display("FAIL read_after_reset_stall: got %0d stall cycles, expected 0", s);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_writes();
      test_back_to_back();
      test_misaligned();
      test_out_of_range();
      test_reset_in_stall();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish by 200000, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ahb2_sram_slv.md
Name: ahb2_sram_slv

Overview:
AHB2 slave that terminates one AHB2_SLV_INTF port and drives a single-port, synchronous, byte-writable SRAM macro.
- Sits directly downstream of the AHB2 decoder/mux and consumes the slave-side signals.
- Zero-wait-state reads and writes, except one stall cycle when a read address phase collides with a pending write data phase.
- Two-cycle ERROR response for illegal transfers.

Parameters:
ADDR_WIDTH, 32, AHB address width
DATA_WIDTH, 32, AHB data width (32 or 64)
MEM_ADDR_WIDTH, 10, SRAM word-address width; decoded window is DATA_WIDTH/8 * 2^MEM_ADDR_WIDTH bytes

Ports:
hclk  input  1  clock
hreset_n  input  1  asynchronous active-low reset
hsel  input  1  slave select from decoder
haddr  input  ADDR_WIDTH  address
htrans  input  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
hwrite  input  1  1=write
hsize  input  3  transfer size (log2 bytes)
hburst  input  3  burst type (ignored; every beat is handled independently)
hprot  input  4  ignored
hwdata  input  DATA_WIDTH  write data (data phase)
hready_in  input  1  bus-level HREADY from the mux
hrdata  output  DATA_WIDTH  read data
hready  output  1  slave ready (HREADYOUT)
hresp  output  2  OKAY=00 ERROR=01; RETRY/SPLIT never issued
mem_cs  output  1  SRAM chip select
mem_we  output  1  SRAM write enable
mem_be  output  DATA_WIDTH/8  SRAM byte enables
mem_addr  output  MEM_ADDR_WIDTH  SRAM word address
mem_wdata  output  DATA_WIDTH  SRAM write data
mem_rdata  input  DATA_WIDTH  SRAM read data, valid the cycle after mem_cs with mem_we=0

Behaviour:
- Interface: one clock, hclk; reset is asynchronous and active-low, hreset_n.
- Reset values:
  - hready=1, hresp=OKAY, hrdata=0.
  - mem_cs=0, mem_we=0, mem_be=0.
  - State IDLE; all captured address-phase registers 0.
- Address phase is accepted when hsel & htrans[1] & hready_in. BUSY and IDLE transfers are not accepted and always get hready=1, hresp=OKAY.
- Legality check at acceptance. A transfer is illegal when any of these holds:
  - hsize > log2(DATA_WIDTH/8);
  - haddr is not aligned to hsize;
  - haddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)+MEM_ADDR_WIDTH] != 0.
- Byte enables: (2^(2^hsize))-1 shifted left by haddr[log2(DATA_WIDTH/8)-1:0]. Captured with the address at acceptance.
- States and transitions:
  - IDLE: no data phase outstanding.
    - Legal write accepted -> WR.
    - Legal read accepted -> issue SRAM read this cycle (mem_cs=1, mem_we=0, mem_addr from haddr) -> RD.
    - Illegal transfer accepted -> ERR1.
  - WR (write data phase):
    - This cycle drives mem_cs=1, mem_we=1, mem_addr/mem_be from captured registers, mem_wdata=hwdata; hready=1, hresp=OKAY.
    - Next state follows the IDLE rules, with one exception: a legal read accepted in this same cycle cannot use the SRAM. Capture its address -> RDS.
  - RDS (read stall):
    - hready=0; issue the captured SRAM read -> RD.
    - No new address phase is accepted, because hready_in is low.
  - RD (read data phase):
    - hrdata=mem_rdata, hready=1, hresp=OKAY.
    - Next state follows the IDLE rules; a new read is issued directly, with no stall.
  - ERR1: hready=0, hresp=ERROR; no SRAM access -> ERR2.
  - ERR2: hready=1, hresp=ERROR -> IDLE. A transfer accepted in ERR2 is processed per the IDLE rules.
- hrdata updates only in RD and holds its value otherwise.
- Illegal writes never assert mem_we.
- mem_cs never asserts in ERR1, ERR2 or IDLE-without-acceptance.
- hready_in low while this slave is in IDLE/WR/RD means another slave is stalling. In that case:
  - no acceptance occurs;
  - a pending WR still completes its SRAM write exactly once;
  - RD keeps presenting hrdata.
- hsel low during an outstanding data phase does not abort that phase.
- Asynchronous reset mid-transfer returns everything to reset values immediately; any write not yet committed is dropped.
- Latency: read data is returned one cycle after the address phase, or two cycles when the read follows a write. Write data is committed in its data-phase cycle.

Test Plan:
- Reset, then NONSEQ write word 0xDEADBEEF @0x10, then read @0x10 -> first read gets hready=0 for exactly 1 cycle (RDS), then hrdata=0xDEADBEEF, hresp=OKAY.
- Byte writes 0x11/0x22/0x33/0x44 @0x20..0x23 (hsize=0), then idle, then word read @0x20 -> mem_be 0001/0010/0100/1000; hrdata=0x44332211; no stall.
- Back-to-back INCR4 reads @0x40 after preloading SRAM 0,1,2,3 -> 4 consecutive hready=1 beats, hrdata 0,1,2,3; mem_cs high 4 cycles.
- Halfword read @0x01 (misaligned) -> hresp=ERROR with hready 0 then 1; no mem_cs; next legal read OKAY.
- Write @0x1000 with MEM_ADDR_WIDTH=10 (out of range) -> two-cycle ERROR; mem_we never asserted; SRAM contents @0x0 unchanged.
- Reset asserted during RDS -> hready=1, hresp=OKAY, mem_cs=0 within the same cycle; after release a read @0x10 completes normally.
